// File: rtl/rede_pkg.sv
// Shared definitions for the layer sequencer: FSM states, activation-function codes
// and the bit layout of a layer descriptor {neuro_m1, bias, fa, ent_m1}.
package rede_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam logic [1:0] FA_0 = 2'd0;
  localparam logic [1:0] FA_1 = 2'd1;
  localparam logic [1:0] FA_2 = 2'd2;
  localparam logic [1:0] FA_3 = 2'd3;

  localparam int unsigned FA_W = 2;

  function automatic int unsigned desc_w(input int unsigned nw);
    return 2 * nw + 3;
  endfunction

  function automatic int unsigned fa_lsb(input int unsigned nw);
    return nw;
  endfunction

  function automatic int unsigned bias_lsb(input int unsigned nw);
    return nw + 2;
  endfunction

  function automatic int unsigned neuro_lsb(input int unsigned nw);
    return nw + 3;
  endfunction

endpackage

// File: rtl/rede_mascara_neuro.sv
// Thermometer neuron-enable mask: bit k set when k <= neuro_m1; large counts saturate to all ones.
module rede_mascara_neuro
  import rede_pkg::*;
#(
  parameter int unsigned MAXN = 20,
  parameter int unsigned NW   = $clog2(MAXN)
) (
  input  logic [NW-1:0]   neuro_m1_i,
  output logic [MAXN-1:0] en_o
);

  always_comb begin
    en_o = '0;
    for (int k = 0; k < MAXN; k++) begin
      en_o[k] = (k <= int'(neuro_m1_i));
    end
    en_o[0] = 1'b1;
  end

endmodule

// File: rtl/rede_sequenciador_camadas.sv
// Multi-layer network sequencer: runs a programmable descriptor table over one input
// vector per inference, driving an external layer unit through a start/done handshake.
//
// state | meaning
// IDLE  | waiting for an input vector; descriptor table writable
// START | one-cycle lyr_start pulse, descriptor fields already registered
// WAIT  | layer unit busy; lyr_done captures masked result
// OUT   | final activations presented until out_ready
module rede_sequenciador_camadas
  import rede_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned MAXN = 20,
  parameter int unsigned MAXL = 4,
  localparam int unsigned LW  = $clog2(MAXL),
  localparam int unsigned NW  = $clog2(MAXN),
  localparam int unsigned CW  = $clog2(MAXL + 1),
  localparam int unsigned DSW = 2 * NW + 3,
  localparam int unsigned VW  = MAXN * DW
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_we_i,
  input  logic [LW-1:0]   cfg_addr_i,
  input  logic [DSW-1:0]  cfg_data_i,
  input  logic [CW-1:0]   cfg_nlayers_i,
  output logic            cfg_err_o,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [VW-1:0]   in_data_i,
  output logic            lyr_start_o,
  output logic [LW-1:0]   lyr_idx_o,
  output logic [NW-1:0]   lyr_qtd_ent_o,
  output logic [1:0]      lyr_fa_o,
  output logic            lyr_bias_o,
  output logic [MAXN-1:0] lyr_en_o,
  output logic [VW-1:0]   lyr_in_o,
  input  logic            lyr_done_i,
  input  logic [VW-1:0]   lyr_out_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [VW-1:0]   out_data_o
);

  state_e         state_q, state_d;
  logic [DSW-1:0] tbl_q [MAXL];
  logic [VW-1:0]  act_q, act_d;
  logic [LW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  nl_q, nl_d;
  logic           in_ready_q, cfg_err_q;
  logic [NW-1:0]  ent_q, ent_d;
  logic [1:0]     fa_q, fa_d;
  logic           bias_q, bias_d;
  logic [MAXN-1:0] en_q, en_d;

  logic           addr_bad, wr_ok, accept, load_desc;
  logic [CW-1:0]  nl_sat;
  logic [LW-1:0]  idx_fetch;
  logic [DSW-1:0] desc_fetch;
  logic [NW-1:0]  ent_raw, ent_sat;
  logic [MAXN-1:0] mask_fetch;
  logic [VW-1:0]  mask_ext;

  assign addr_bad = (32'(cfg_addr_i) >= MAXL);
  assign wr_ok    = cfg_we_i && (state_q == ST_IDLE) && !addr_bad;
  assign accept   = in_valid_i && in_ready_q;
  assign nl_sat   = (cfg_nlayers_i > CW'(MAXL)) ? CW'(MAXL) : cfg_nlayers_i;

  // A write landing in the accept cycle must be visible to layer 0, hence the bypass.
  assign idx_fetch  = (state_q == ST_WAIT) ? idx_q + LW'(1) : '0;
  assign desc_fetch = (wr_ok && cfg_addr_i == idx_fetch) ? cfg_data_i : tbl_q[idx_fetch];
  assign ent_raw    = desc_fetch[NW-1:0];
  assign ent_sat    = (32'(ent_raw) >= MAXN) ? NW'(MAXN - 1) : ent_raw;

  rede_mascara_neuro #(.MAXN(MAXN), .NW(NW)) u_mascara (
    .neuro_m1_i (desc_fetch[neuro_lsb(NW) +: NW]),
    .en_o       (mask_fetch)
  );

  always_comb begin
    mask_ext = '0;
    for (int k = 0; k < MAXN; k++) begin
      mask_ext[k*DW +: DW] = {DW{en_q[k]}};
    end
  end

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    idx_d     = idx_q;
    nl_d      = nl_q;
    load_desc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          act_d = in_data_i;
          nl_d  = nl_sat;
          idx_d = '0;
          if (nl_sat == '0) begin
            state_d = ST_OUT;
          end else begin
            state_d   = ST_START;
            load_desc = 1'b1;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (lyr_done_i) begin
          act_d = lyr_out_i & mask_ext;
          if (CW'(idx_q) + CW'(1) < nl_q) begin
            idx_d     = idx_q + LW'(1);
            state_d   = ST_START;
            load_desc = 1'b1;
          end else begin
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: if (out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ent_d  = ent_q;
    fa_d   = fa_q;
    bias_d = bias_q;
    en_d   = en_q;
    if (load_desc) begin
      ent_d  = ent_sat;
      fa_d   = desc_fetch[fa_lsb(NW) +: FA_W];
      bias_d = desc_fetch[bias_lsb(NW)];
      en_d   = mask_fetch;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      act_q      <= '0;
      idx_q      <= '0;
      nl_q       <= '0;
      in_ready_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      ent_q      <= '0;
      fa_q       <= '0;
      bias_q     <= 1'b0;
      en_q       <= '0;
      for (int i = 0; i < MAXL; i++) tbl_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      idx_q      <= idx_d;
      nl_q       <= nl_d;
      in_ready_q <= (state_d == ST_IDLE);
      cfg_err_q  <= cfg_we_i && !wr_ok;
      ent_q      <= ent_d;
      fa_q       <= fa_d;
      bias_q     <= bias_d;
      en_q       <= en_d;
      if (wr_ok) tbl_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  assign cfg_err_o     = cfg_err_q;
  assign in_ready_o    = in_ready_q;
  assign lyr_start_o   = (state_q == ST_START);
  assign lyr_idx_o     = idx_q;
  assign lyr_qtd_ent_o = ent_q;
  assign lyr_fa_o      = fa_q;
  assign lyr_bias_o    = bias_q;
  assign lyr_en_o      = en_q;
  assign lyr_in_o      = act_q;
  assign out_valid_o   = (state_q == ST_OUT);
  assign out_data_o    = act_q;

endmodule

// File: tb/tb_rede_sequenciador_camadas.sv
// Self-checking bench: the bench plays the layer unit and predicts every handshake
// and vector from a table model of the descriptor rules.
module tb_rede_sequenciador_camadas;

  localparam int DW = 8, MAXN = 20, MAXL = 4;
  localparam int LW = 2, NW = 5, CW = 3, DSW = 13, VW = MAXN * DW;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            cfg_we_i = 1'b0;
  logic [LW-1:0]   cfg_addr_i = '0;
  logic [DSW-1:0]  cfg_data_i = '0;
  logic [CW-1:0]   cfg_nlayers_i = '0;
  logic            cfg_err_o;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [VW-1:0]   in_data_i = '0;
  logic            lyr_start_o;
  logic [LW-1:0]   lyr_idx_o;
  logic [NW-1:0]   lyr_qtd_ent_o;
  logic [1:0]      lyr_fa_o;
  logic            lyr_bias_o;
  logic [MAXN-1:0] lyr_en_o;
  logic [VW-1:0]   lyr_in_o;
  logic            lyr_done_i = 1'b0;
  logic [VW-1:0]   lyr_out_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [VW-1:0]   out_data_o;

  always #5 clk_i = ~clk_i;

  rede_sequenciador_camadas dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_nlayers_i(cfg_nlayers_i), .cfg_err_o(cfg_err_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .lyr_start_o(lyr_start_o), .lyr_idx_o(lyr_idx_o), .lyr_qtd_ent_o(lyr_qtd_ent_o),
    .lyr_fa_o(lyr_fa_o), .lyr_bias_o(lyr_bias_o), .lyr_en_o(lyr_en_o), .lyr_in_o(lyr_in_o),
    .lyr_done_i(lyr_done_i), .lyr_out_i(lyr_out_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o)
  );

  int n_checks = 0;
  int n_fail = 0;
  int start_cnt = 0;
  logic [DSW-1:0] tbl_m [MAXL];

  always @(posedge clk_i) if (lyr_start_o) start_cnt <= start_cnt + 1;

  task automatic check_val(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DSW-1:0] mkdesc(input int neuro, input int bias, input int fa, input int ent);
    logic [DSW-1:0] d;
    d = {5'(neuro), 1'(bias), 2'(fa), 5'(ent)};
    return d;
  endfunction

  function automatic logic [MAXN-1:0] exp_en(input logic [DSW-1:0] d);
    logic [MAXN-1:0] e;
    int nm;
    nm = int'(d[12:8]);
    e = '0;
    for (int k = 0; k < MAXN; k++) if (k <= nm) e[k] = 1'b1;
    return e;
  endfunction

  function automatic logic [NW-1:0] exp_qtd(input logic [DSW-1:0] d);
    int ent;
    ent = int'(d[4:0]);
    return (ent > MAXN - 1) ? NW'(MAXN - 1) : NW'(ent);
  endfunction

  function automatic logic [VW-1:0] apply_mask(input logic [VW-1:0] v, input logic [MAXN-1:0] en);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < MAXN; k++) if (en[k]) r[k*DW +: DW] = v[k*DW +: DW];
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec(input bit ff_heavy);
    logic [VW-1:0] r;
    for (int k = 0; k < MAXN; k++)
      r[k*DW +: DW] = (ff_heavy && $urandom_range(1) == 1) ? 8'hFF : 8'($urandom);
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ctrl"}, VW'({cfg_err_o, in_ready_o, lyr_start_o, lyr_idx_o, lyr_qtd_ent_o,
                                   lyr_fa_o, lyr_bias_o, lyr_en_o, out_valid_o}), VW'(0));
    check_val({tag, "_lyr_in"}, lyr_in_o, '0);
    check_val({tag, "_out_data"}, out_data_o, '0);
  endtask

  task automatic cfg_write(input int a, input logic [DSW-1:0] d);
    cfg_we_i = 1'b1; cfg_addr_i = LW'(a); cfg_data_i = d;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    check_val("cfg_err_ok", VW'(cfg_err_o), VW'(0));
    tbl_m[a] = d;
  endtask

  task automatic run_inference(input logic [VW-1:0] vec, input int nl, input int bp,
                               input bit bad_cfg, input bit wr_acc, input logic [DSW-1:0] wr_data);
    int L, waitc, s0;
    logic [VW-1:0] act, lo;
    logic [DSW-1:0] d;
    logic [MAXN-1:0] en;
    waitc = 0;
    while (!in_ready_o && waitc < 20) begin @(negedge clk_i); waitc++; end
    check_val("in_ready_before_accept", VW'(in_ready_o), VW'(1));
    if (wr_acc) begin
      cfg_we_i = 1'b1; cfg_addr_i = '0; cfg_data_i = wr_data; tbl_m[0] = wr_data;
    end
    in_valid_i = 1'b1; in_data_i = vec; cfg_nlayers_i = CW'(nl);
    s0 = start_cnt;
    L = (nl > MAXL) ? MAXL : nl;
    act = vec;
    @(negedge clk_i);
    in_valid_i = 1'b0; cfg_we_i = 1'b0;
    for (int l = 0; l < L; l++) begin
      d = tbl_m[l];
      en = exp_en(d);
      check_val("lyr_start_pulse", VW'(lyr_start_o), VW'(1));
      check_val("lyr_idx", VW'(lyr_idx_o), VW'(l));
      check_val("lyr_qtd_ent", VW'(lyr_qtd_ent_o), VW'(exp_qtd(d)));
      check_val("lyr_fa", VW'(lyr_fa_o), VW'(d[6:5]));
      check_val("lyr_bias", VW'(lyr_bias_o), VW'(d[7]));
      check_val("lyr_en", VW'(lyr_en_o), VW'(en));
      check_val("lyr_in", lyr_in_o, act);
      @(negedge clk_i);
      check_val("lyr_start_single", VW'(lyr_start_o), VW'(0));
      if (bad_cfg && l == 0) begin
        cfg_we_i = 1'b1; cfg_addr_i = LW'($urandom); cfg_data_i = DSW'($urandom);
        @(negedge clk_i);
        cfg_we_i = 1'b0;
        check_val("cfg_err_wait", VW'(cfg_err_o), VW'(1));
        @(negedge clk_i);
        check_val("cfg_err_one_cycle", VW'(cfg_err_o), VW'(0));
      end
      repeat ($urandom_range(3)) @(negedge clk_i);
      lo = rand_vec(1'b1);
      lyr_done_i = 1'b1; lyr_out_i = lo;
      act = apply_mask(lo, en);
      @(negedge clk_i);
      lyr_done_i = 1'b0; lyr_out_i = rand_vec(1'b0);
    end
    check_val("start_count", VW'(start_cnt - s0), VW'(L));
    check_val("out_valid", VW'(out_valid_o), VW'(1));
    check_val("out_data", out_data_o, act);
    check_val("in_ready_busy", VW'(in_ready_o), VW'(0));
    repeat (bp) begin
      @(negedge clk_i);
      check_val("bp_out_valid", VW'(out_valid_o), VW'(1));
      check_val("bp_out_data", out_data_o, act);
      check_val("bp_in_ready", VW'(in_ready_o), VW'(0));
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check_val("out_valid_drop", VW'(out_valid_o), VW'(0));
    check_val("in_ready_return", VW'(in_ready_o), VW'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VW-1:0] v;
    for (int i = 0; i < MAXL; i++) tbl_m[i] = '0;

    // reset state
    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_val("in_ready_after_reset", VW'(in_ready_o), VW'(1));

    // three layers with shrinking neuron counts
    cfg_write(0, mkdesc(19, $urandom_range(1), $urandom_range(3), $urandom_range(19)));
    cfg_write(1, mkdesc(9, $urandom_range(1), $urandom_range(3), $urandom_range(19)));
    cfg_write(2, mkdesc(4, $urandom_range(1), $urandom_range(3), $urandom_range(19)));
    run_inference(rand_vec(1'b0), 3, 0, 1'b0, 1'b0, '0);
    check_val("hi_elems_zero", VW'(out_data_o[VW-1:5*DW]), VW'(0));

    // zero-layer bypass
    v = rand_vec(1'b0);
    v[7:0] = 8'h5A;
    run_inference(v, 0, 0, 1'b0, 1'b0, '0);
    check_val("bypass_elem0", VW'(out_data_o[7:0]), VW'(8'h5A));

    // backpressure
    run_inference(rand_vec(1'b0), 2, 10, 1'b0, 1'b0, '0);

    // rejected write in WAIT, then a run that must see the old table
    run_inference(rand_vec(1'b0), 3, 1, 1'b1, 1'b0, '0);
    run_inference(rand_vec(1'b0), 3, 0, 1'b0, 1'b0, '0);

    // write and accept in the same cycle
    run_inference(rand_vec(1'b0), 2, 0, 1'b0, 1'b1, mkdesc(2, 1, 3, 7));

    // saturation: layer count, neuron mask, input count
    cfg_write(3, mkdesc(31, 1, 2, 31));
    run_inference(rand_vec(1'b0), 7, 2, 1'b0, 1'b0, '0);

    // spurious done while idle
    lyr_done_i = 1'b1; lyr_out_i = rand_vec(1'b0);
    @(negedge clk_i);
    lyr_done_i = 1'b0;
    check_val("spurious_done_valid", VW'(out_valid_o), VW'(0));
    check_val("spurious_done_start", VW'(lyr_start_o), VW'(0));
    check_val("spurious_done_ready", VW'(in_ready_o), VW'(1));

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(2)) cfg_write($urandom_range(MAXL - 1),
        mkdesc($urandom_range(31), $urandom_range(1), $urandom_range(3), $urandom_range(31)));
      run_inference(rand_vec(1'b0), $urandom_range(7), $urandom_range(3), 1'b0, 1'b0, '0);
    end

    // reset in the middle of a layer
    in_valid_i = 1'b1; in_data_i = rand_vec(1'b0); cfg_nlayers_i = 3'd2;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("reset_mid_wait");
    for (int i = 0; i < MAXL; i++) tbl_m[i] = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_val("in_ready_after_mid_reset", VW'(in_ready_o), VW'(1));
    lyr_done_i = 1'b1; lyr_out_i = rand_vec(1'b1);
    @(negedge clk_i);
    lyr_done_i = 1'b0;
    repeat (3) begin
      check_val("late_done_no_valid", VW'(out_valid_o), VW'(0));
      @(negedge clk_i);
    end
    run_inference(rand_vec(1'b0), 1, 0, 1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
